sevseg_scan_ctrl: RTL

Time-multiplexed scan controller for a common-anode multi-digit seven-segment display. It holds a frame of hex nibbles, decimal points and per-digit blank flags, and walks the digits in round-robin order. Each digit gets a dark guard interval followed by a lit dwell interval, and the block decodes that digit's nibble to active-low segments. It sits between the debug/status register logic, which loads frames through a valid/ready handshake, and the board anode/cathode pins.

---
 rtl/sevseg_scan_ctrl.sv | 92 +++++++++
 1 files changed

// File: rtl/sevseg_scan_ctrl.sv
// sevseg_scan_ctrl: round-robin scan controller for a common-anode multi-digit seven-segment display
module sevseg_scan_ctrl #(
  parameter int NUM_DIGITS   = 8,
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic [NUM_DIGITS-1:0]   load_dp,
  input  logic [NUM_DIGITS-1:0]   load_blank,
  input  logic                    load_valid,
  output logic                    load_ready,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic [7:0]              seg_n,
  output logic                    frame_done
);
  localparam int MAXC = DIGIT_CYCLES > BLANK_CYCLES ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam bit HAS_G = BLANK_CYCLES > 0;
  localparam logic [CW-1:0] G_LAST = CW'(HAS_G ? BLANK_CYCLES - 1 : 0);
  localparam logic [CW-1:0] S_LAST = CW'(DIGIT_CYCLES - 1);
  localparam logic [IW-1:0] I_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [16*7-1:0] PAT = {7'h71, 7'h79, 7'h5E, 7'h58, 7'h7C, 7'h77, 7'h67, 7'h7F,
                                     7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};
  typedef enum logic {GUARD, SHOW} state_t;
  localparam state_t ST_RST = HAS_G ? GUARD : SHOW;
  state_t                  st, nxt_st;
  logic [CW-1:0]           cnt, nxt_cnt;
  logic [IW-1:0]           idx, nxt_idx;
  logic [4*NUM_DIGITS-1:0] act_data, pend_data, nxt_data;
  logic [NUM_DIGITS-1:0]   act_dp, pend_dp, nxt_dp;
  logic [NUM_DIGITS-1:0]   act_blank, pend_blank, nxt_blank;
  logic                    last, digit_end, wrap, swap, accept, lit;
  logic [3:0]              nib;
  logic [NUM_DIGITS-1:0]   an_d;
  logic [7:0]              seg_d;
  // pending slot is full exactly when load_ready is low
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st         <= ST_RST;
      cnt        <= '0;
      idx        <= '0;
      act_data   <= '0;
      act_dp     <= '0;
      act_blank  <= '1;
      pend_data  <= '0;
      pend_dp    <= '0;
      pend_blank <= '0;
      load_ready <= 1'b1;
      an_n       <= '1;
      seg_n      <= 8'hFF;
      frame_done <= 1'b0;
    end else begin
      st         <= nxt_st;
      cnt        <= nxt_cnt;
      idx        <= nxt_idx;
      act_data   <= nxt_data;
      act_dp     <= nxt_dp;
      act_blank  <= nxt_blank;
      if (accept) begin
        pend_data  <= load_data;
        pend_dp    <= load_dp;
        pend_blank <= load_blank;
      end
      load_ready <= ~accept & (load_ready | swap);
      an_n       <= an_d;
      seg_n      <= seg_d;
      frame_done <= wrap;
    end
  always_comb begin
    last      = st == GUARD ? cnt == G_LAST : cnt == S_LAST;
    digit_end = st == SHOW && last;
    wrap      = digit_end && idx == I_LAST;
    nxt_st    = last ? (st == GUARD ? SHOW : (HAS_G ? GUARD : SHOW)) : st;
    nxt_cnt   = last ? '0 : cnt + 1'b1;
    nxt_idx   = digit_end ? (wrap ? '0 : idx + 1'b1) : idx;
    accept    = load_valid && load_ready;
    swap      = wrap && !load_ready;
    nxt_data  = swap ? pend_data : act_data;
    nxt_dp    = swap ? pend_dp : act_dp;
    nxt_blank = swap ? pend_blank : act_blank;
  end
  // outputs are registered from next-state values so they line up with the state they describe
  always_comb begin
    lit   = nxt_st == SHOW && !nxt_blank[nxt_idx];
    nib   = nxt_data[4*nxt_idx +: 4];
    an_d  = lit ? ~(NUM_DIGITS'(1) << nxt_idx) : '1;
    seg_d = lit ? ~{nxt_dp[nxt_idx], PAT[7*nib +: 7]} : 8'hFF;
  end
endmodule
